// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C target
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      REG,
      REG_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      IGNORE
   } i2c_state_t;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - pin synchronizer with single-cycle rise/fall pulses
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Reset to the idle-high bus level so release of reset never looks like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target decoding register writes and serving register reads
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEVICE_ADDR = 7'h39,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start, stop;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk(clk), .rst(rst), .pin(scl_in), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk(clk), .rst(rst), .pin(sda_in), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
   );

   assign start = sda_fall & scl_lvl;
   assign stop  = sda_rise & scl_lvl;

   i2c_state_t state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d;
   logic [7:0] wr_addr_d, wr_data_d;
   logic       sda_oe_d, wr_en_d, busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= 4'd0;
         shift_q   <= 8'd0;
         tx_q      <= 8'd0;
         ptr_q     <= 8'd0;
         sda_oe    <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= 8'd0;
         wr_data   <= 8'd0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         ptr_q     <= ptr_d;
         sda_oe    <= sda_oe_d;
         wr_en     <= wr_en_d;
         wr_addr   <= wr_addr_d;
         wr_data   <= wr_data_d;
         busy      <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
      busy_d    = busy;

      if (wr_en)
         ptr_d = ptr_q + 8'd1;

      if (stop) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start) begin
         state_d   = ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            ADDR, REG, WDATA: begin
               if (scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = {shift_q[6:0], sda_lvl};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (state_q == WDATA && bit_cnt_q == 4'd7) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = ptr_q;
                     wr_data_d = {shift_q[6:0], sda_lvl};
                  end
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  if (state_q == ADDR) begin
                     if (shift_q[7:1] == DEVICE_ADDR) begin
                        state_d  = ADDR_ACK;
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                     end else begin
                        state_d = IGNORE;
                     end
                  end else if (state_q == REG) begin
                     ptr_d    = shift_q;
                     sda_oe_d = 1'b1;
                     state_d  = REG_ACK;
                  end else begin
                     sda_oe_d = 1'b1;
                     state_d  = WDATA_ACK;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = 4'd0;
                  if (shift_q[0]) begin
                     tx_d     = rd_data;
                     sda_oe_d = ~rd_data[7];
                     state_d  = RDATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = REG;
                  end
               end
            end
            REG_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 4'd0;
                  state_d   = WDATA;
               end
            end
            // bit_cnt 8 here means the master ACKed and the next byte loads on the coming fall.
            RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     tx_d      = rd_data;
                     sda_oe_d  = ~rd_data[7];
                     bit_cnt_d = 4'd0;
                  end else if (bit_cnt_q == 4'd7) begin
                     sda_oe_d = 1'b0;
                     state_d  = RDATA_ACK;
                  end else begin
                     tx_d      = {tx_q[6:0], 1'b0};
                     sda_oe_d  = ~tx_q[6];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            RDATA_ACK: begin
               if (scl_rise) begin
                  if (sda_lvl == ACK) begin
                     ptr_d     = ptr_q + 8'd1;
                     bit_cnt_d = 4'd8;
                     state_d   = RDATA;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign rd_addr = ptr_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - randomized scoreboard bench for i2c_target
`timescale 1ns/1ps
module tb_i2c_target;

   localparam int         Q        = 6;
   localparam logic [6:0] DEV      = 7'h39;
   localparam int         K_ACK    = 0;
   localparam int         K_RD     = 1;
   localparam int         K_RDADDR = 2;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rf_init = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       scl_in, sda_in, sda_oe, wr_en, busy;
   logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
   logic [7:0] regfile [256];
   logic [7:0] mregs [256];
   logic [7:0] txq [$];
   ev_t        exp_q [$];
   ev_t        obs_q [$];
   int         exp_wr_q [$];
   int         mp = 0;
   int         checks = 0;
   int         errors = 0;
   logic       prev_oe = 1'b0;

   always #5 clk = ~clk;

   assign scl_in  = m_scl;
   assign sda_in  = m_sda & ~sda_oe;
   assign rd_data = regfile[rd_addr];

   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 256; i++) regfile[i] <= 8'(i * 37 + 11);
      end else if (wr_en) begin
         regfile[wr_addr] <= wr_data;
      end
   end

   i2c_target #(.DEVICE_ADDR(DEV), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
      .rd_data(rd_data), .busy(busy)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h required=nothing", name, act);
   endtask

   function automatic ev_t mk(input int k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      return e;
   endfunction

   function automatic string kname(input int k);
      return (k == K_ACK) ? "ack_bit" : (k == K_RD) ? "read_byte" : "rd_addr";
   endfunction

   // Monitor: pops expectations whenever the DUT or the bus presents a result.
   initial begin
      ev_t o, e;
      forever begin
         @(negedge clk);
         if (wr_en) begin
            if (exp_wr_q.size() == 0) fail("unexpected_wr_en", int'({wr_addr, wr_data}));
            else check("wr_addr_data", int'({wr_addr, wr_data}), exp_wr_q.pop_front());
         end
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
               fail("unexpected_event", o.val);
            end else begin
               e = exp_q.pop_front();
               check("event_kind", o.kind, e.kind);
               check(kname(e.kind), o.val, e.val);
            end
         end
         if (!rst && sda_oe !== prev_oe) check("sda_oe_moves_scl_low", int'(m_scl), 0);
         prev_oe = sda_oe;
      end
   end

   initial begin
      #3000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic wq(input int n = 1);
      repeat (n * Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wq();
      m_scl = 1'b1; wq();
      m_sda = 1'b0; wq();
      m_scl = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wq();
      m_scl = 1'b1; wq();
      m_sda = 1'b1; wq();
   endtask

   task automatic wbit(input logic b);
      m_sda = b; wq();
      m_scl = 1'b1; wq(2);
      m_scl = 1'b0; wq();
   endtask

   task automatic rbit(output logic b);
      m_sda = 1'b1; wq();
      m_scl = 1'b1; wq();
      b = sda_in; wq();
      m_scl = 1'b0; wq();
   endtask

   task automatic send(input logic [7:0] b, input int exp_ack);
      logic a;
      exp_q.push_back(mk(K_ACK, exp_ack));
      for (int i = 7; i >= 0; i--) wbit(b[i]);
      rbit(a);
      obs_q.push_back(mk(K_ACK, int'(a)));
   endtask

   task automatic read_byte(output logic [7:0] b, input logic ack, input bit chk_addr);
      logic x;
      for (int i = 7; i >= 0; i--) begin
         rbit(x);
         b[i] = x;
         if (i == 4 && chk_addr) obs_q.push_back(mk(K_RDADDR, int'(rd_addr)));
      end
      wbit(ack);
   endtask

   // Model: first byte after a matched write address is the pointer, the rest are writes.
   task automatic do_write(input logic [6:0] a);
      bit hit;
      hit = (a == DEV);
      i2c_start();
      send({a, 1'b0}, hit ? 0 : 1);
      check("busy_after_addr", int'(busy), int'(hit));
      foreach (txq[i]) begin
         if (hit) begin
            if (i == 0) begin
               mp = int'(txq[i]);
            end else begin
               exp_wr_q.push_back(int'({mp[7:0], txq[i]}));
               mregs[mp] = txq[i];
               mp = (mp + 1) % 256;
            end
         end
         send(txq[i], hit ? 0 : 1);
      end
      i2c_stop(); wq();
      check("busy_after_stop", int'(busy), 0);
      check("sda_oe_after_stop", int'(sda_oe), 0);
   endtask

   task automatic do_read(input logic [6:0] a, input logic [7:0] r, input int n, input bit extra);
      bit         hit;
      logic [7:0] b;
      logic       x;
      hit = (a == DEV);
      i2c_start();
      send({a, 1'b0}, hit ? 0 : 1);
      send(r, hit ? 0 : 1);
      if (hit) mp = int'(r);
      i2c_start();
      send({a, 1'b1}, hit ? 0 : 1);
      check("busy_read_addr", int'(busy), int'(hit));
      for (int k = 0; k < n; k++) begin
         if (hit) exp_q.push_back(mk(K_RDADDR, mp));
         exp_q.push_back(mk(K_RD, hit ? int'(mregs[mp]) : 255));
         read_byte(b, (k == n - 1), hit);
         obs_q.push_back(mk(K_RD, int'(b)));
         if (hit && k != n - 1) mp = (mp + 1) % 256;
      end
      if (extra) begin
         exp_q.push_back(mk(K_RD, 255));
         for (int i = 7; i >= 0; i--) begin
            rbit(x);
            b[i] = x;
         end
         obs_q.push_back(mk(K_RD, int'(b)));
      end
      i2c_stop(); wq();
      check("busy_after_read", int'(busy), 0);
      check("sda_oe_after_read", int'(sda_oe), 0);
   endtask

   initial begin
      logic [6:0] a;
      for (int i = 0; i < 256; i++) mregs[i] = 8'(i * 37 + 11);
      rf_init = 1'b1;
      repeat (3) @(negedge clk);
      rf_init = 1'b0;
      check("rst_sda_oe", int'(sda_oe), 0);
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_wr_data", int'(wr_data), 0);
      check("rst_rd_addr", int'(rd_addr), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      wq();

      txq = '{8'h41, 8'h10};
      do_write(DEV);
      do_write(7'h3A);
      txq = '{8'hFE, 8'hAA, 8'hBB, 8'hCC};
      do_write(DEV);
      txq = '{8'h20, 8'h5A, 8'hC3};
      do_write(DEV);
      do_read(DEV, 8'h20, 2, 1'b1);

      // Abort a data byte after four bits.
      i2c_start();
      send({DEV, 1'b0}, 0);
      send(8'h50, 0);
      mp = 8'h50;
      for (int i = 0; i < 4; i++) wbit(1'($urandom));
      i2c_stop(); wq();
      check("partial_busy", int'(busy), 0);
      check("partial_sda_oe", int'(sda_oe), 0);

      // Reset while the address ACK is being driven.
      i2c_start();
      for (int i = 7; i >= 1; i--) wbit(DEV[i-1]);
      wbit(1'b0);
      check("ack_driven", int'(sda_oe), 1);
      #2 rst = 1'b1;
      #1 check("oe_async_rst", int'(sda_oe), 0);
      check("busy_async_rst", int'(busy), 0);
      check("rd_addr_async_rst", int'(rd_addr), 0);
      @(negedge clk);
      rst = 1'b0;
      mp = 0;
      i2c_stop();
      txq = '{8'h07, 8'h99};
      do_write(DEV);

      for (int t = 0; t < 14; t++) begin
         a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : DEV;
         if ($urandom_range(0, 1) == 1) begin
            txq.delete();
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) txq.push_back(8'($urandom));
            do_write(a);
         end else begin
            do_read(a, 8'($urandom), int'($urandom_range(1, 3)), 1'b0);
         end
      end

      wq(4);
      check("wr_queue_drained", exp_wr_q.size(), 0);
      check("event_queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) for the same 2-byte register-write protocol the config master issues: device address, register address byte, then data byte(s).
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Exposes decoded register writes and register reads to a register file through a simple strobe interface.
- Used as an on-chip config slave and as a bus-functional responder when verifying the HDMI config path.

Parameters:
- DEVICE_ADDR, 7'h39, 7-bit target address matched against the first byte after START.
- SYNC_STAGES, 2, flip-flop stages on SCL and SDA inputs before edge detection (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- rst  in  1  asynchronous, active-high reset.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- wr_en  out  1  one-cycle register-write strobe.
- wr_addr  out  8  register address for wr_en.
- wr_data  out  8  data for wr_en.
- rd_addr  out  8  register address being read; held stable through each read byte.
- rd_data  in  8  register value at rd_addr; sampled one cycle before the first bit is driven.
- busy  out  1  1 from address match until STOP.

Behaviour:
- Reset values: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, state IDLE, register pointer 0.
- Input path: SCL/SDA pass SYNC_STAGES flops, then one edge-detect register.
- scl_rise/scl_fall are single-cycle pulses, 3 clk after the pin edge (default).
- START: SDA falls while synced SCL=1. STOP: SDA rises while synced SCL=1.
- Data is sampled only on scl_rise. sda_oe changes only on the cycle after scl_fall.
- STOP in any state: go to IDLE, sda_oe=0, busy=0 that cycle.
- START in any state, including repeated START mid-transfer: go to ADDR, bit counter = 0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first.
    - If bits[7:1]==DEVICE_ADDR: go to ADDR_ACK, busy=1.
    - Otherwise: go to IGNORE (sda_oe stays 0 until STOP or START).
  - ADDR_ACK: assert sda_oe for the 9th clock (from scl_fall after bit 8 to the next scl_fall).
    - R/W=0: go to REG.
    - R/W=1: load the tx shift register from rd_data, then go to RDATA.
  - REG: shift 8 bits into the pointer. Then REG_ACK (ACK driven), then WDATA.
  - WDATA: shift 8 bits.
    - On the 8th scl_rise, the next cycle: wr_en=1 for exactly one clk, wr_addr=pointer, wr_data=byte.
    - Pointer increments the cycle after wr_en.
    - Then WDATA_ACK (ACK driven), then WDATA again.
  - RDATA: drive tx bits MSB-first. sda_oe = ~bit; a 1 bit is released, never driven high.
    - After the 8th bit, release SDA and go to RDATA_ACK.
  - RDATA_ACK: sample the master's ACK on scl_rise.
    - ACK (0): pointer+1, rd_addr updates, rd_data sampled, go to RDATA.
    - NACK (1): go to IGNORE, busy stays 1 until STOP.
- Pointer wraps 8'hFF to 8'h00 with no flag.
- rd_addr always mirrors the pointer.
- START/STOP inside a byte aborts that byte; no wr_en is issued for a partial byte.
- Asynchronous rst mid-transfer: all outputs return to reset values immediately; SDA is released.

Decomposition:
- Package i2c_pkg: state enumeration (IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE), plus constants for ACK=0 and NACK=1.
- Sub-module i2c_line_sync: synchronizer plus edge detect. Outputs the synced level, rise pulse and fall pulse. Instantiated twice, once for SCL and once for SDA.
- Top: FSM, bit counter (0-8), shift registers, pointer.

Test Plan:
- Write 0x39/W, reg 0x41, data 0x10, STOP -> three ACKs (SDA low on 9th clocks); one wr_en with wr_addr=0x41, wr_data=0x10; busy falls at STOP.
- Address 0x3A/W -> no ACK (SDA released on 9th clock), no wr_en, busy stays 0.
- Write 0x39/W, reg 0xFE, data 0xAA, 0xBB, 0xCC -> wr_en pulses at addresses 0xFE, 0xFF, 0x00 with matching data.
- Write reg 0x20, repeated START, 0x39/R, rd_data returns 0x5A then 0xC3, master ACKs then NACKs, STOP:
  - SDA bits are 01011010 then 11000011.
  - rd_addr is 0x20 then 0x21.
  - No extra byte is driven after the NACK.
- STOP after 4 data bits of a write byte -> no wr_en, state IDLE, sda_oe=0.
- Assert rst while sda_oe=1 during an ACK -> sda_oe=0 the same cycle; the next valid transaction completes normally.
